// File: rtl/btn_pkg.sv
// btn_pkg: shared state encoding, default divider and rate_sel codes for the button front-end
package btn_pkg;
    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;
    localparam int DEFAULT_TICK_DIV = 100000;
    localparam logic [1:0] RATE_X1 = 2'd0;
    localparam logic [1:0] RATE_X2 = 2'd1;
    localparam logic [1:0] RATE_X4 = 2'd2;
    localparam logic [1:0] RATE_X8 = 2'd3;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: sampling-tick divider, period TICK_DIV << rate_q, rate latched only at period boundaries
module tick_gen
    import btn_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] rate_sel,
    output logic       tick
);
    localparam int CW = $clog2(TICK_DIV * 8);
    logic [CW-1:0] count;
    logic [1:0]    rate_q;
    logic [CW:0]   last;
    assign last = ((CW+1)'(TICK_DIV) << rate_q) - (CW+1)'(1);
    assign tick = {1'b0, count} == last;
    // rate_q only moves on a tick so a rate change never alters the running period
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            count  <= '0;
            rate_q <= rate_sel;
        end else if (tick) begin
            count  <= '0;
            rate_q <= rate_sel;
        end else begin
            count  <= count + 1'b1;
        end
endmodule

// File: rtl/btn_debounce_ctrl.sv
// btn_debounce_ctrl: synchronise, debounce and classify N_BTN push-buttons into level, press pulse and long-press hold
module btn_debounce_ctrl
    import btn_pkg::*;
#(
    parameter int N_BTN        = 5,
    parameter int TICK_DIV     = DEFAULT_TICK_DIV,
    parameter int STABLE_TICKS = 4,
    parameter int HOLD_TICKS   = 500
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       rate_sel,
    input  logic [N_BTN-1:0] btn_raw,
    output logic             sample_tick,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse,
    output logic [N_BTN-1:0] btn_hold
);
    localparam int CMAX = HOLD_TICKS > STABLE_TICKS ? HOLD_TICKS : STABLE_TICKS;
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_TICKS - 1);
    localparam logic [CW-1:0] HOLD_MAX    = CW'(HOLD_TICKS);
    logic             tick;
    logic [N_BTN-1:0] sync_meta, s;
    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clock    (clock),
        .reset    (reset),
        .rate_sel (rate_sel),
        .tick     (tick)
    );
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            sync_meta   <= '0;
            s           <= '0;
            sample_tick <= 1'b0;
        end else begin
            sync_meta   <= btn_raw;
            s           <= sync_meta;
            sample_tick <= tick;
        end
    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        logic [1:0]    state;
        logic [CW-1:0] cnt;
        logic          level, pulse, hold;
        always_ff @(posedge clock or posedge reset)
            if (reset) begin
                state <= ST_IDLE;
                cnt   <= '0;
                level <= 1'b0;
                pulse <= 1'b0;
                hold  <= 1'b0;
            end else begin
                pulse <= 1'b0;
                if (tick) begin
                    case (state)
                        ST_IDLE:
                            if (s[g]) begin
                                state <= ST_PRESS_WAIT;
                                cnt   <= CW'(1);
                            end
                        ST_PRESS_WAIT:
                            if (!s[g]) begin
                                state <= ST_IDLE;
                            end else if (cnt == STABLE_LAST) begin
                                state <= ST_PRESSED;
                                cnt   <= '0;
                                level <= 1'b1;
                                pulse <= 1'b1;
                            end else begin
                                cnt   <= cnt + 1'b1;
                            end
                        ST_PRESSED:
                            if (!s[g]) begin
                                state <= ST_RELEASE_WAIT;
                                cnt   <= CW'(1);
                            end else if (cnt < HOLD_MAX) begin
                                cnt   <= cnt + 1'b1;
                                if (cnt == HOLD_MAX - 1'b1) hold <= 1'b1;
                            end
                        default:
                            // a bounce back to pressed keeps an earned hold, otherwise hold timing restarts
                            if (s[g]) begin
                                state <= ST_PRESSED;
                                cnt   <= hold ? HOLD_MAX : '0;
                            end else if (cnt == STABLE_LAST) begin
                                state <= ST_IDLE;
                                level <= 1'b0;
                                hold  <= 1'b0;
                            end else begin
                                cnt   <= cnt + 1'b1;
                            end
                    endcase
                end
            end
        assign btn_level[g] = level;
        assign btn_pulse[g] = pulse;
        assign btn_hold[g]  = hold;
    end
endmodule

// File: doc/btn_debounce_ctrl.md
# btn_debounce_ctrl

- Multi-button front-end controller for the Basys3 push-buttons.
- Contains a programmable sampling-tick generator: the slow-rate divider, with its rate selected at run time.
- Sequences per-button debounce state machines from that tick.
- Outputs to the lab top-level: a clean level, a single-cycle press pulse and a long-press flag per button.

## Interface
Parameters:
- N_BTN, 5, number of buttons handled.
- TICK_DIV, 100000, base tick period in clock cycles (1 kHz at 100 MHz).
- STABLE_TICKS, 4, consecutive equal samples needed to accept a transition (≥2).
- HOLD_TICKS, 500, ticks in PRESSED before btn_hold asserts (≥1).

Ports:
- clock  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high reset.
- rate_sel  in  2  tick period = TICK_DIV << rate_sel cycles.
- btn_raw  in  N_BTN  asynchronous button inputs.
- sample_tick  out  1  registered copy of the internal tick, for debug/LED.
- btn_level  out  N_BTN  debounced level.
- btn_pulse  out  N_BTN  one-clock pulse on accepted press.
- btn_hold  out  N_BTN  high while a press is held ≥ HOLD_TICKS.

## Operation
- Synchroniser: each btn_raw bit passes through 2 flops; the FSMs see only the synchronised value s.
- Tick generator:
  - Counter runs 0 .. P−1, where P = TICK_DIV << rate_q.
  - tick = (count == P−1); the counter wraps to 0 on tick.
  - rate_q loads rate_sel at reset and on every tick only. A rate change never truncates or extends the current period.
  - Counter width = clog2(TICK_DIV·8).
- Per-button FSM, evaluated only in tick cycles, with tick counter cnt:
  - IDLE:
    - s=1 → PRESS_WAIT, cnt=1.
  - PRESS_WAIT:
    - s=0 → IDLE.
    - s=1 and cnt==STABLE_TICKS−1 → PRESSED, cnt=0; btn_level←1, btn_pulse←1 for one clock.
    - Otherwise cnt++.
  - PRESSED:
    - s=0 → RELEASE_WAIT, cnt=1.
    - Otherwise, if cnt<HOLD_TICKS, cnt++. When cnt reaches HOLD_TICKS, btn_hold←1. cnt saturates.
  - RELEASE_WAIT:
    - s=1 → PRESSED. cnt is restored to HOLD_TICKS if btn_hold=1, else to 0 (hold timing restarts).
    - s=0 and cnt==STABLE_TICKS−1 → IDLE; btn_level←0, btn_hold←0.
    - Otherwise cnt++.
- Buttons are fully independent. Simultaneous presses each produce their own pulse in the same cycle.
- Reset, asserted at any time including mid-debounce:
  - All FSMs → IDLE; counters, rate_q←rate_sel, synchronisers and every output → 0.
  - A button already held at reset release is treated as a new press and needs STABLE_TICKS samples.

## Timing
- Reset values: sample_tick=0, btn_level=0, btn_pulse=0, btn_hold=0.
- All outputs are registered and update on the clock edge following the tick cycle.
- First tick occurs P cycles after reset deassertion (count reaches P−1).
- Press latency from a clean btn_raw rise:
  - 2 synchroniser cycles,
  - then STABLE_TICKS tick samples (the first sample is at the next tick),
  - plus 1 cycle.
  - Release latency is symmetric.
- btn_pulse is high for exactly one clock per accepted press; it is never asserted while btn_level is already 1.
- Any glitch shorter than STABLE_TICKS consecutive samples causes no output change.

## Structure
- Shared package btn_pkg holds:
  - the FSM state encoding (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT; 2 bits),
  - the default TICK_DIV,
  - the rate_sel encoding constants.
- Sub-module tick_gen (clock, reset, rate_sel → tick) holds the divider counter and rate_q.
- The debounce FSM is a generate loop over N_BTN, or an optional sub-module btn_fsm.

## Test plan
Bench parameters: TICK_DIV=4, STABLE_TICKS=3, HOLD_TICKS=8, rate_sel=0 (tick every 4 cycles).
- Reset then idle 40 cycles → sample_tick pulses every 4 cycles starting at cycle 4; all button outputs stay 0.
- btn_raw[0] rises cleanly and stays high → btn_pulse[0] high exactly 1 cycle at the 3rd tick after sync, +1 cycle; btn_level[0]=1; btn_hold[0]=1 after 8 further ticks; release → level and hold drop 3 ticks later.
- btn_raw[1] toggles with 2-tick highs (bounce) → no pulse. Then steady high → exactly one pulse.
- btn_raw[2] and btn_raw[4] rise in the same cycle → both pulses asserted in the same cycle; other bits stay 0.
- rate_sel changed 0→2 mid-period → the current period completes at 4 cycles; subsequent ticks are every 16 cycles.
- Reset asserted in PRESS_WAIT (count 2 of 3) with the button still held → all outputs 0 immediately; after release of reset, the pulse comes 3 ticks later, not 1.
